// File: rtl/fr_pkg.sv
// Shared constants, FSM state type and saturation helper for the fr layer engine.
package fr_pkg;

    localparam int N_IN      = 21;
    localparam int N_OUT     = 5;
    localparam int FRAC_BITS = 8;
    localparam int ACC_W     = 40;
    localparam int DATA_W    = 16;
    localparam int PROD_W    = 32;
    localparam int ROW_W     = 3;
    localparam int COL_W     = 5;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_OUT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_IN - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        DRAIN,
        EMIT
    } state_t;

    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return 16'sh7fff;
        end else if (v < SAT_MIN) begin
            return 16'sh8000;
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/fr_mac_unit.sv
// Two-stage multiply/accumulate path: stage 1 registers the product, stage 2
// accumulates and presents the saturated Q7.8 result on the row's last tap.
module fr_mac_unit
    import fr_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     first,
    input  logic                     last,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic                     res_valid,
    output logic signed [DATA_W-1:0] res
);

    logic signed [PROD_W-1:0] prod_q;
    logic                     valid_q;
    logic                     first_q;
    logic                     last_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            prod_q  <= a * b;
            valid_q <= in_valid;
            first_q <= first;
            last_q  <= last;
        end
    end

    always_comb begin
        acc_next = first_q ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (valid_q) begin
            acc_q <= acc_next;
        end
    end

    // Result is taken from the accumulate-in-progress value so the buffer write
    // lands in the same cycle the last product is accumulated.
    assign res_valid = valid_q & last_q;
    assign res       = sat16(acc_next >>> FRAC_BITS);

endmodule

// File: rtl/fr_layer_engine.sv
// fr layer sequencer: loads a feature vector, walks the weight memory and
// streams out one mean/variance pair per output filter.
module fr_layer_engine
    import fr_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [15:0]       in_data,
    output logic                     w_start,
    output logic [2:0]               w_output_filter_m,
    output logic [2:0]               w_output_filter_v,
    output logic [4:0]               w_input_filter,
    input  logic signed [15:0]       w_m,
    input  logic signed [15:0]       w_v,
    input  logic                     w_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_idx,
    output logic signed [15:0]       out_mean,
    output logic signed [15:0]       out_var,
    output logic                     done
);

    state_t                   state;
    logic [COL_W-1:0]         k;
    logic [COL_W-1:0]         col;
    logic [ROW_W-1:0]         row;
    logic [ROW_W-1:0]         row_q;
    logic                     drain_cnt;

    logic signed [DATA_W-1:0] x        [N_IN];
    logic signed [DATA_W-1:0] sq       [N_IN];
    logic signed [DATA_W-1:0] res_mean [N_OUT];
    logic signed [DATA_W-1:0] res_var  [N_OUT];

    logic signed [PROD_W-1:0] in_sq;
    logic                     in_fire;
    logic                     out_fire;
    logic                     mac_valid;
    logic                     mac_first;
    logic                     mac_last;
    logic                     m_res_valid;
    logic                     v_res_valid;
    logic signed [DATA_W-1:0] m_res;
    logic signed [DATA_W-1:0] v_res;

    assign in_fire   = (state == LOAD) && in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign in_sq     = in_data * in_data;
    assign mac_valid = (state == COMPUTE);
    assign mac_first = (col == '0);
    assign mac_last  = (col == COL_LAST);

    assign w_output_filter_m = row;
    assign w_output_filter_v = row;
    assign w_input_filter    = col;

    // done marks the accepting cycle of the final result itself.
    assign done = !rst && out_fire && (out_idx == ROW_LAST);

    fr_mac_unit u_mac_m (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (mac_valid),
        .first     (mac_first),
        .last      (mac_last),
        .a         (x[col]),
        .b         (w_m),
        .res_valid (m_res_valid),
        .res       (m_res)
    );

    fr_mac_unit u_mac_v (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (mac_valid),
        .first     (mac_first),
        .last      (mac_last),
        .a         (sq[col]),
        .b         (w_v),
        .res_valid (v_res_valid),
        .res       (v_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned j = 0; j < N_IN; j++) begin
                x[j]  <= '0;
                sq[j] <= '0;
            end
            for (int unsigned j = 0; j < N_OUT; j++) begin
                res_mean[j] <= '0;
                res_var[j]  <= '0;
            end
            row_q <= '0;
        end else begin
            if (in_fire) begin
                x[k]  <= in_data;
                sq[k] <= sat16(ACC_W'(in_sq >>> FRAC_BITS));
            end
            if (mac_valid) begin
                row_q <= row;
            end
            if (m_res_valid) begin
                res_mean[row_q] <= m_res;
            end
            if (v_res_valid) begin
                res_var[row_q] <= v_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            in_ready  <= 1'b0;
            w_start   <= 1'b0;
            k         <= '0;
            row       <= '0;
            col       <= '0;
            drain_cnt <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_mean  <= '0;
            out_var   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (in_fire) begin
                        if (k == COL_LAST) begin
                            k        <= '0;
                            in_ready <= 1'b0;
                            w_start  <= 1'b1;
                            state    <= COMPUTE;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (col == COL_LAST) begin
                        col <= '0;
                        if (row == ROW_LAST) begin
                            row       <= '0;
                            w_start   <= 1'b0;
                            drain_cnt <= 1'b0;
                            state     <= DRAIN;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state     <= EMIT;
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                        out_mean  <= res_mean[0];
                        out_var   <= res_var[0];
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        if (out_idx == ROW_LAST) begin
                            out_valid <= 1'b0;
                            out_idx   <= '0;
                            out_mean  <= '0;
                            out_var   <= '0;
                            in_ready  <= 1'b1;
                            state     <= LOAD;
                        end else begin
                            out_idx  <= out_idx + 1'b1;
                            out_mean <= res_mean[out_idx + 1'b1];
                            out_var  <= res_var[out_idx + 1'b1];
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

`ifndef SYNTHESIS
    wdone_check: assert property (@(posedge clk) disable iff (rst) w_start |-> w_done)
        else $error("w_done low while w_start asserted");
`endif

endmodule
